// File: rtl/fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_drain
//  Description : Read-side consumer for the dual-clock FIFO. It pops through
//                the FIFO read port, prefetches into a small local buffer and
//                presents a valid/ready stream with a per-frame last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_drain #(
    parameter int DSIZE     = 12,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2,
    parameter int FRAME_LEN = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic             busy
);

    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int c_IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int c_FLT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RD_LAT-1:0]  pipe_q, pipe_d;
    logic [DSIZE-1:0]   buf_q [BUF_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_IDX_W-1:0] idx_q, idx_d;

    logic [c_FLT_W-1:0] w_inflight;
    logic               w_land;
    logic               w_pop;
    logic [31:0]        w_occ;
    logic               w_credit;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Tap of the read-latency pipe marks the word landing on this edge.
    generate
        if (RD_LAT == 1) begin : g_pipe_one
            assign pipe_d = rinc;
        end else begin : g_pipe_shift
            assign pipe_d = {pipe_q[RD_LAT-2:0], rinc};
        end
    endgenerate

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_FLT_W'(pipe_q[i]);
        end
    end

    assign w_land = pipe_q[RD_LAT-1];
    assign w_pop  = m_valid & m_ready;

    // A slot freed by this cycle's pop is reusable now; without that credit
    // the steady state would stall every other cycle at BUF_DEPTH = RD_LAT+1.
    assign w_occ    = 32'(cnt_q) + 32'(w_inflight) - {31'd0, w_pop};
    assign w_credit = (w_occ < 32'(BUF_DEPTH));
    assign rinc     = (state_q == S_RUN) && !rempty && w_credit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (en) begin
                    state_d = S_RUN;
                end else if ((w_inflight == '0) && (cnt_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = w_land ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        case ({w_land, w_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        idx_d = idx_q;
        if (w_pop) begin
            idx_d = (idx_q == c_IDX_W'(FRAME_LEN - 1)) ? '0 : idx_q + c_IDX_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= S_IDLE;
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pipe_q   <= pipe_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            if (w_land) begin
                buf_q[wr_ptr_q] <= rdata;
            end
        end
    end

    assign m_valid = (cnt_q != '0);
    assign m_data  = buf_q[rd_ptr_q];
    assign m_last  = m_valid && (idx_q == c_IDX_W'(FRAME_LEN - 1));
    assign busy    = (state_q != S_IDLE) || (w_inflight != '0) || m_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_drain
//  Description : Directed bench for fifo_rd_drain with a FIFO read-port model
//                and an in-order scoreboard of popped words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_drain;

    localparam int DSIZE     = 12;
    localparam int FRAME_LEN = 8;

    logic             rclk = 1'b0;
    logic             rrst;
    logic             en;
    logic             rempty;
    logic [DSIZE-1:0] rdata = '0;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
    logic             busy;

    logic [DSIZE-1:0] fifo_mem [256];
    int               wr_idx = 0;
    int               rd_idx = 0;
    logic [DSIZE-1:0] exp_q [$];
    int               sb_idx = 0;
    int               n_vec  = 0;
    int               n_err  = 0;
    int               n_xfer = 0;

    always #5 rclk = ~rclk;

    assign rempty = (wr_idx == rd_idx);

    fifo_rd_drain #(
        .DSIZE     (DSIZE),
        .RD_LAT    (1),
        .BUF_DEPTH (2),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .en      (en),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_mem[wr_idx[7:0]] = w;
        wr_idx++;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // FIFO read port: registered data one cycle after a sampled pop.
    always @(posedge rclk) begin
        if (rrst !== 1'b1 && rinc === 1'b1) begin
            rdata  <= fifo_mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
            exp_q.push_back(fifo_mem[rd_idx[7:0]]);
        end
    end

    task automatic monitor();
        logic [DSIZE-1:0] w;
        if (rrst === 1'b1) begin
            exp_q.delete();
            sb_idx = 0;
        end else if (rrst === 1'b0) begin
            check("rinc_while_empty", 32'(rinc & rempty), 32'd0);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_xfer++;
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_extra_word: observed 0x%0h expected none", m_data);
                end
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("sb_data", 32'(m_data), 32'(w));
                    check("sb_last", 32'(m_last), 32'(sb_idx == FRAME_LEN - 1));
                    sb_idx = (sb_idx + 1) % FRAME_LEN;
                end
            end
        end
    endtask

    always @(negedge rclk) monitor();

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rinc;
        int x0;
        rrst    = 1'b1;
        en      = 1'b1;
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(DSIZE'(i));

        // Reset: everything quiet although en=1 and the FIFO is non-empty.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rinc",    32'(rinc),    32'd0);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_data",  32'(m_data),  32'd0);
            check("rst_m_last",  32'(m_last),  32'd0);
            check("rst_busy",    32'(busy),    32'd0);
        end
        rrst    = 1'b0;
        m_ready = 1'b1;
        check("idle_rinc", 32'(rinc), 32'd0);
        tick();
        check("first_rinc", 32'(rinc), 32'd1);
        check("run_busy",   32'(busy), 32'd1);
        tick();
        check("fill_m_valid", 32'(m_valid), 32'd0);
        tick();

        // Streaming: one word per cycle, last on 0x008 and 0x010.
        for (int i = 0; i < 16; i++) begin
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data",  32'(m_data),  32'(i + 1));
            check("stream_last",  32'(m_last),  32'((i % 8) == 7));
            tick();
        end
        check("stream_done_valid", 32'(m_valid), 32'd0);
        check("stream_sb_empty",   32'(exp_q.size()), 32'd0);

        // Backpressure.
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DSIZE'(12'h100 + i));
        n_rinc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            if (rinc === 1'b1) n_rinc++;
            if (i >= 3) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data",  32'(m_data),  32'h101);
            end
            tick();
        end
        check("stall_rinc_count", 32'(n_rinc), 32'd2);
        check("stall_rinc_low",   32'(rinc),   32'd0);
        m_ready = 1'b1;
        repeat (12) tick();
        check("bp_sb_empty",     32'(exp_q.size()), 32'd0);
        check("bp_fifo_drained", 32'(wr_idx - rd_idx), 32'd0);
        check("bp_done_valid",   32'(m_valid), 32'd0);

        // Empty boundary: a single word.
        x0 = n_xfer;
        push(12'h2AA);
        n_rinc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            if (rinc === 1'b1) n_rinc++;
            tick();
        end
        check("one_word_rinc", 32'(n_rinc), 32'd1);
        check("one_word_xfer", 32'(n_xfer - x0), 32'd1);

        // Drain: drop en with one word buffered and one in flight.
        m_ready = 1'b0;
        push(12'h301);
        push(12'h302);
        push(12'h303);
        tick();
        tick();
        check("pre_drain_valid", 32'(m_valid), 32'd1);
        check("pre_drain_busy",  32'(busy),    32'd1);
        en = 1'b0;
        @(negedge rclk);
        check("drain_no_rinc", 32'(rinc), 32'd0);
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            check("drain_no_rinc", 32'(rinc), 32'd0);
            tick();
        end
        check("drain_busy",      32'(busy),    32'd0);
        check("drain_valid",     32'(m_valid), 32'd0);
        check("drain_sb_empty",  32'(exp_q.size()), 32'd0);
        check("drain_fifo_left", 32'(wr_idx - rd_idx), 32'd1);
        for (int i = 4; i <= 9; i++) push(DSIZE'(12'h300 + i));
        en = 1'b1;
        repeat (14) tick();
        check("resume_sb_empty", 32'(exp_q.size()), 32'd0);
        check("resume_valid",    32'(m_valid), 32'd0);

        // Mid-reset with a full, stalled buffer and a non-zero frame index.
        push(12'h401);
        push(12'h402);
        push(12'h403);
        repeat (8) tick();
        m_ready = 1'b0;
        for (int i = 4; i <= 7; i++) push(DSIZE'(12'h400 + i));
        repeat (5) tick();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_data",  32'(m_data),  32'h404);
        rrst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_last",  32'(m_last),  32'd0);
        check("mid_rst_busy",  32'(busy),    32'd0);
        check("mid_rst_rinc",  32'(rinc),    32'd0);
        rrst    = 1'b0;
        m_ready = 1'b1;
        for (int i = 8; i <= 13; i++) push(DSIZE'(12'h400 + i));
        repeat (20) tick();
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        check("post_rst_fifo",     32'(wr_idx - rd_idx), 32'd0);
        check("post_rst_valid",    32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
